// File: rtl/rep_string_seq.sv
// String-instruction sequencer: issues ESI/EDI uops per iteration, steps pointers, counts ECX.
// Optional segment-limit check enabled by defining SEG_LIMIT_CHK_EN.
module rep_string_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_v,
  input  logic [1:0]  i_rep,
  input  logic        i_two,
  input  logic [31:0] i_ecx,
  input  logic [31:0] i_esi,
  input  logic [31:0] i_edi,
  input  logic [1:0]  i_opSize,
  input  logic        i_Dflag,
  input  logic        i_stall,
  input  logic        i_zf_v,
  input  logic        i_zf,
  input  logic        i_flush,
  input  logic [31:0] i_lim_src,
  input  logic [31:0] i_lim_dst,
  output logic        o_busy,
  output logic        o_v,
  output logic [1:0]  o_uopNo,
  output logic [31:0] o_addr,
  output logic        o_lastuop,
  output logic [31:0] o_ecx,
  output logic [31:0] o_esi,
  output logic [31:0] o_edi,
  output logic        o_done,
  output logic        o_fault
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE0,
    ISSUE1,
    WAIT_ZF,
    DONE
  } state_t;

  state_t      state;
  state_t      state_n;
  state_t      first_st;

  logic [1:0]  rep_q;
  logic [1:0]  sz_q;
  logic        two_q;
  logic        dflag_q;
  logic [31:0] ecx_q;
  logic [31:0] esi_q;
  logic [31:0] edi_q;
  logic [31:0] step;
  logic        issuing;
  logic        fault;
  logic        iter_end;
  logic        ld;

  // Pointer step size from operand size.
  always_comb begin
    step = 32'd1;
    unique case (sz_q)
      2'b10:   step = 32'd2;
      2'b11:   step = 32'd4;
      default: step = 32'd1;
    endcase
  end

  assign issuing  = (state == ISSUE0) || (state == ISSUE1);
  assign first_st = two_q ? ISSUE0 : ISSUE1;

`ifdef SEG_LIMIT_CHK_EN
  logic [31:0] lim_src_q;
  logic [31:0] lim_dst_q;
  logic [32:0] end_addr;
  logic [32:0] lim_sel;

  // Last byte touched by the pending uop against its segment limit.
  always_comb begin
    end_addr = {1'b0, o_addr} + {1'b0, step} - 33'd1;
    lim_sel  = (state == ISSUE0) ? {1'b0, lim_src_q}
                                 : {1'b0, lim_dst_q};
    fault    = issuing && (end_addr > lim_sel);
  end

  // Limits captured with the instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      lim_src_q <= '0;
      lim_dst_q <= '0;
    end else if (!i_flush && state == IDLE && i_v) begin
      lim_src_q <= i_lim_src;
      lim_dst_q <= i_lim_dst;
    end
  end
`else
  logic unused_lim;
  assign unused_lim = ^{i_lim_src, i_lim_dst};
  assign fault      = 1'b0;
`endif

  assign ld       = (state == IDLE) && i_v;
  assign iter_end = (state == ISSUE1) && !i_stall && !fault;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (i_v) begin
          if (i_rep != 2'b00 && i_ecx == 32'd0) state_n = DONE;
          else if (i_two)                       state_n = ISSUE0;
          else                                  state_n = ISSUE1;
        end
      end
      ISSUE0: begin
        if (fault)         state_n = IDLE;
        else if (!i_stall) state_n = ISSUE1;
      end
      ISSUE1: begin
        if (fault) begin
          state_n = IDLE;
        end else if (!i_stall) begin
          if (rep_q == 2'b00)       state_n = DONE;
          else if (rep_q[1])        state_n = WAIT_ZF;
          else if (ecx_q == 32'd1)  state_n = DONE;
          else                      state_n = first_st;
        end
      end
      WAIT_ZF: begin
        if (i_zf_v) begin
          if (ecx_q == 32'd0 ||
              (rep_q == 2'b10 && !i_zf) ||
              (rep_q == 2'b11 && i_zf))
            state_n = DONE;
          else
            state_n = first_st;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (i_flush) state_n = IDLE;
  end

  // Instruction latch and per-iteration pointer/count update.
  always_ff @(posedge clk) begin
    if (reset) begin
      rep_q   <= '0;
      sz_q    <= '0;
      two_q   <= 1'b0;
      dflag_q <= 1'b0;
      ecx_q   <= '0;
      esi_q   <= '0;
      edi_q   <= '0;
    end else if (!i_flush) begin
      if (ld) begin
        rep_q   <= i_rep;
        sz_q    <= i_opSize;
        two_q   <= i_two;
        dflag_q <= i_Dflag;
        ecx_q   <= i_ecx;
        esi_q   <= i_esi;
        edi_q   <= i_edi;
      end else if (iter_end) begin
        if (two_q)
          esi_q <= dflag_q ? esi_q - step : esi_q + step;
        edi_q <= dflag_q ? edi_q - step : edi_q + step;
        if (rep_q != 2'b00)
          ecx_q <= ecx_q - 32'd1;
      end
    end
  end

  // Uop and status outputs.
  always_comb begin
    o_busy    = (state != IDLE);
    o_v       = issuing && !fault;
    o_uopNo   = (state == ISSUE1) ? 2'd1 : 2'd0;
    o_addr    = '0;
    if (state == ISSUE0) o_addr = esi_q;
    if (state == ISSUE1) o_addr = edi_q;
    o_lastuop = (state == ISSUE1) &&
                (rep_q == 2'b00 || ecx_q == 32'd1);
    o_done    = (state == DONE);
    o_fault   = fault && !i_flush;
  end

  assign o_ecx = ecx_q;
  assign o_esi = esi_q;
  assign o_edi = edi_q;

endmodule

// File: tb/tb_rep_string_seq.sv
// Directed bench for rep_string_seq with a uop scoreboard.
// Fault scenario runs only when SEG_LIMIT_CHK_EN is defined.
module tb_rep_string_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_v;
  logic [1:0]  i_rep;
  logic        i_two;
  logic [31:0] i_ecx;
  logic [31:0] i_esi;
  logic [31:0] i_edi;
  logic [1:0]  i_opSize;
  logic        i_Dflag;
  logic        i_stall;
  logic        i_zf_v;
  logic        i_zf;
  logic        i_flush;
  logic [31:0] i_lim_src;
  logic [31:0] i_lim_dst;
  logic        o_busy;
  logic        o_v;
  logic [1:0]  o_uopNo;
  logic [31:0] o_addr;
  logic        o_lastuop;
  logic [31:0] o_ecx;
  logic [31:0] o_esi;
  logic [31:0] o_edi;
  logic        o_done;
  logic        o_fault;

  typedef struct {
    logic [1:0]  uop;
    logic [31:0] addr;
    logic        last;
  } uop_t;

  uop_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;
  int   d0;

  rep_string_seq dut (
    .clk(clk), .reset(reset), .i_v(i_v), .i_rep(i_rep),
    .i_two(i_two), .i_ecx(i_ecx), .i_esi(i_esi), .i_edi(i_edi),
    .i_opSize(i_opSize), .i_Dflag(i_Dflag), .i_stall(i_stall),
    .i_zf_v(i_zf_v), .i_zf(i_zf), .i_flush(i_flush),
    .i_lim_src(i_lim_src), .i_lim_dst(i_lim_dst),
    .o_busy(o_busy), .o_v(o_v), .o_uopNo(o_uopNo), .o_addr(o_addr),
    .o_lastuop(o_lastuop), .o_ecx(o_ecx), .o_esi(o_esi),
    .o_edi(o_edi), .o_done(o_done), .o_fault(o_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] u, input logic [31:0] a,
                      input logic l);
    uop_t e;
    e.uop = u; e.addr = a; e.last = l;
    sb.push_back(e);
  endtask

  // Scoreboard: compare each transferred uop against the queue head.
  always @(negedge clk) begin
    if (!reset && o_done) done_cnt++;
    if (!reset && o_v && !i_stall) begin
      if (sb.size() == 0) begin
        chk("unexpected_uop", o_addr, 32'hFFFF_FFFF);
      end else begin
        uop_t e;
        e = sb.pop_front();
        chk("uop_no", {30'd0, o_uopNo}, {30'd0, e.uop});
        chk("uop_addr", o_addr, e.addr);
        chk("uop_last", {31'd0, o_lastuop}, {31'd0, e.last});
      end
    end
  end

  // Drive one instruction for a single sampling edge.
  task automatic start(input logic [1:0] rep, input logic two,
                       input logic [31:0] ecx, input logic [31:0] esi,
                       input logic [31:0] edi, input logic [1:0] sz,
                       input logic d);
    i_v = 1'b1; i_rep = rep; i_two = two; i_ecx = ecx;
    i_esi = esi; i_edi = edi; i_opSize = sz; i_Dflag = d;
    @(posedge clk); #1;
    i_v = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!o_busy) break;
    end
    chk(tag, {31'd0, o_busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic zf_iter(input logic z);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (o_v) break;
    end
    chk("zf_uop_seen", {31'd0, o_v}, 32'd1);
    @(posedge clk); #1;
    i_zf_v = 1'b1; i_zf = z;
    @(posedge clk); #1;
    i_zf_v = 1'b0; i_zf = 1'b0;
  endtask

  initial begin
    reset = 1'b1; i_v = 1'b0; i_rep = 2'b00; i_two = 1'b0;
    i_ecx = '0; i_esi = '0; i_edi = '0; i_opSize = 2'b00;
    i_Dflag = 1'b0; i_stall = 1'b0; i_zf_v = 1'b0; i_zf = 1'b0;
    i_flush = 1'b0; i_lim_src = 32'hFFFF_FFFF; i_lim_dst = 32'hFFFF_FFFF;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_v", {31'd0, o_v}, 32'd0);
    chk("rst_addr", o_addr, 32'd0);
    chk("rst_ecx", o_ecx, 32'd0);
    chk("rst_esi", o_esi, 32'd0);
    chk("rst_edi", o_edi, 32'd0);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    chk("rst_fault", {31'd0, o_fault}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // MOVS dword REP ECX=3
    push(0, 32'h1000, 0); push(1, 32'h2000, 0);
    push(0, 32'h1004, 0); push(1, 32'h2004, 0);
    push(0, 32'h1008, 0); push(1, 32'h2008, 1);
    d0 = done_cnt;
    start(2'b01, 1'b1, 32'd3, 32'h1000, 32'h2000, 2'b11, 1'b0);
    wait_idle("movs_idle");
    chk("movs_done", done_cnt - d0, 32'd1);
    chk("movs_sb_empty", sb.size(), 32'd0);
    chk("movs_ecx", o_ecx, 32'd0);
    chk("movs_esi", o_esi, 32'h100C);
    chk("movs_edi", o_edi, 32'h200C);

    // STOS byte REP ECX=0
    d0 = done_cnt;
    start(2'b01, 1'b0, 32'd0, 32'h0, 32'h500, 2'b00, 1'b0);
    @(negedge clk);
    chk("stos0_done", {31'd0, o_done}, 32'd1);
    chk("stos0_v", {31'd0, o_v}, 32'd0);
    chk("stos0_ecx", o_ecx, 32'd0);
    wait_idle("stos0_idle");
    chk("stos0_done_cnt", done_cnt - d0, 32'd1);

    // SCAS word REPNE ECX=5 D=1
    push(1, 32'h10, 0); push(1, 32'h0E, 0);
    d0 = done_cnt;
    start(2'b11, 1'b0, 32'd5, 32'h0, 32'h10, 2'b10, 1'b1);
    zf_iter(1'b0);
    zf_iter(1'b1);
    wait_idle("scas_idle");
    chk("scas_done", done_cnt - d0, 32'd1);
    chk("scas_sb_empty", sb.size(), 32'd0);
    chk("scas_ecx", o_ecx, 32'd3);
    chk("scas_edi", o_edi, 32'h0C);

    // MOVS word, no REP: ECX untouched
    push(0, 32'h50, 0); push(1, 32'h60, 1);
    start(2'b00, 1'b1, 32'd7, 32'h50, 32'h60, 2'b10, 1'b0);
    wait_idle("single_idle");
    chk("single_ecx", o_ecx, 32'd7);
    chk("single_esi", o_esi, 32'h52);
    chk("single_edi", o_edi, 32'h62);

    // STOS dword REP ECX=2 with a 3-cycle stall
    push(1, 32'h3000, 0); push(1, 32'h3004, 1);
    i_stall = 1'b1;
    start(2'b01, 1'b0, 32'd2, 32'h0, 32'h3000, 2'b11, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_v", {31'd0, o_v}, 32'd1);
      chk("stall_addr", o_addr, 32'h3000);
      chk("stall_ecx", o_ecx, 32'd2);
    end
    @(posedge clk); #1;
    i_stall = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_iter_ecx", o_ecx, 32'd1);
    chk("stall_iter_edi", o_edi, 32'h3004);
    wait_idle("stall_idle");
    chk("stall_sb_empty", sb.size(), 32'd0);

    // MOVS dword REP ECX=4, flushed on the 2nd EDI uop
    push(0, 32'h100, 0); push(1, 32'h200, 0);
    push(0, 32'h104, 0); push(1, 32'h204, 0);
    d0 = done_cnt;
    start(2'b01, 1'b1, 32'd4, 32'h100, 32'h200, 2'b11, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("flush_pre_addr", o_addr, 32'h204);
    i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
    @(negedge clk);
    chk("flush_v", {31'd0, o_v}, 32'd0);
    chk("flush_busy", {31'd0, o_busy}, 32'd0);
    chk("flush_ecx", o_ecx, 32'd3);
    chk("flush_esi", o_esi, 32'h104);
    chk("flush_edi", o_edi, 32'h204);
    chk("flush_no_done", done_cnt - d0, 32'd0);
    chk("flush_sb_empty", sb.size(), 32'd0);
    @(posedge clk); #1;

`ifdef SEG_LIMIT_CHK_EN
    // STOS dword past the destination limit
    i_lim_dst = 32'hFFF;
    d0 = done_cnt;
    start(2'b00, 1'b0, 32'd1, 32'h0, 32'hFFE, 2'b11, 1'b0);
    @(negedge clk);
    chk("fault_pulse", {31'd0, o_fault}, 32'd1);
    chk("fault_no_v", {31'd0, o_v}, 32'd0);
    @(negedge clk);
    chk("fault_idle", {31'd0, o_busy}, 32'd0);
    chk("fault_once", {31'd0, o_fault}, 32'd0);
    chk("fault_no_done", done_cnt - d0, 32'd0);
    chk("fault_edi", o_edi, 32'hFFE);
    i_lim_dst = 32'hFFFF_FFFF;
`endif

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
